serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Upstream stimulus stage for the Moore "101" sequence detector: accepts parallel words over a valid/ready handshake and serialises them into the single-bit `x` stream the detector samples on each clock. A holding register plus a shift register give gap-free streaming of back-to-back words. A `stall` input freezes the stream, and a `word_done` pulse marks the end of each word.

## Interface
- `WIDTH`, 8: bits per word (≥2).
- `CNT_W`, 3: bit-counter width; must satisfy 2^CNT_W ≥ WIDTH.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  holding register empty; word accepted when `din_valid & din_ready` at a rising edge.
- `stall`  in  1  freeze shifting and loading while high.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a real data bit.
- `busy`  out  1  shifting in progress, or holding register full.
- `word_done`  out  1  one-cycle pulse after the last bit of a word is shifted out.

## Operation
- Storage: holding register `hreg` with flag `hvalid`; shift register `sreg`; bit counter `cnt`; FSM states IDLE and SHIFT.
- Outputs derived from state:
  - `din_ready = ~hvalid` (combinational).
  - `busy = (state==SHIFT) | hvalid`.
  - `x = x_valid ? sreg[WIDTH-1] : 0`, so the detector sees 0 when idle.
- Accept: on an edge with `din_valid & din_ready`, `hreg <= din` and `hvalid <= 1`. Acceptance is independent of `stall`.
- IDLE:
  - If `hvalid & ~stall`: load `sreg <= hreg`, clear `hvalid`, set `cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, `~stall`, `cnt < WIDTH-1`: `sreg <= sreg << 1` and `cnt <= cnt+1`.
- SHIFT, `~stall`, `cnt == WIDTH-1` (last bit): pulse `word_done`, then:
  - If `hvalid`: reload `sreg <= hreg`, clear `hvalid`, set `cnt <= 0`, stay in SHIFT. No idle bit is inserted.
  - Else: go to IDLE; `x_valid` falls.
- SHIFT with `stall`: `sreg`, `cnt`, `x` and `x_valid` all hold.
- Accept and reload on the same edge are impossible, because `din_ready` is low whenever `hvalid` is 1. `din_ready` rises in the cycle after a reload.

## Timing
- Reset (async assert, sync-free release) values:
  - state IDLE; `sreg`, `hreg` and `cnt` = 0; `hvalid` = 0.
  - `x` = 0, `x_valid` = 0, `busy` = 0, `word_done` = 0, `din_ready` = 1.
- Latency: word accepted at edge N → `hvalid` = 1 after N → transfer at edge N+1 → first bit on `x` with `x_valid` = 1 after N+1.
- A word occupies exactly WIDTH unstalled cycles on `x`.
- `word_done` is registered: high for the single cycle following the edge that consumed the last bit, whether or not another word follows.
- Sustained throughput: one word per WIDTH cycles when `din` is presented within WIDTH-1 cycles of the previous reload.
- Reset mid-word: the word in flight and any held word are discarded. No `word_done` pulse; `x` drops to 0 immediately.

## Configuration
- `SERIAL_LSB_FIRST_EN`:
  - Defined: `x` is taken from `sreg[0]` and `sreg` shifts right; bits go out LSB first.
  - Undefined (default): MSB first, as described above.
  - Counter, handshake and timing are identical in both builds.

## Test plan
- Single word: reset low 2 cycles, release, present `din`=8'hA5 for one accept → `x` = 1,0,1,0,0,1,0,1 on cycles N+2..N+9 with `x_valid`=1; `word_done`=1 on cycle N+10 only; `x`=0 after.
- Back-to-back: 8'hB4, then 8'h5A accepted while the first is shifting → 16 contiguous valid bits 10110100 01011010; `word_done` pulses twice, 8 cycles apart; no gap.
- Backpressure: with `hreg` full during SHIFT, hold `din_valid`=1 → `din_ready`=0 until the cycle after the reload; no word is lost or duplicated.
- Stall: assert `stall` for 3 cycles after the 3rd bit of 8'hA5 → `x` holds 1 for those 3 cycles; total valid cycles = 11; bit order unchanged.
- Reset mid-word: drop `reset` after the 4th bit → `x`, `x_valid` and `busy` are 0 immediately; `din_ready`=1; no `word_done`.
- `SERIAL_LSB_FIRST_EN` build: `din`=8'h0D → `x` = 1,0,1,1,0,0,0,0; a downstream detector reports "101" once at the 3rd bit.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Serialiser feeding the "101" detector: holding register + shift register give gap-free streaming.
// Define SERIAL_LSB_FIRST_EN to shift LSB first; default build shifts MSB first.
module serial_bit_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             stall,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hreg_q, hreg_d;
    logic             hvalid_q, hvalid_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             out_bit;

`ifdef SERIAL_LSB_FIRST_EN
    assign sreg_shifted = sreg_q >> 1;
    assign out_bit      = sreg_q[0];
`else
    assign sreg_shifted = sreg_q << 1;
    assign out_bit      = sreg_q[WIDTH-1];
`endif

    always_comb begin
        state_d     = state_q;
        hreg_d      = hreg_q;
        hvalid_d    = hvalid_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;

        // Accept only when empty, so it can never collide with a transfer out of hreg.
        if (din_valid && !hvalid_q) begin
            hreg_d   = din;
            hvalid_d = 1'b1;
        end

        if (!stall) begin
            if (state_q == IDLE) begin
                if (hvalid_q) begin
                    sreg_d   = hreg_q;
                    hvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end else if (cnt_q != LAST) begin
                sreg_d = sreg_shifted;
                cnt_d  = cnt_q + 1'b1;
            end else begin
                word_done_d = 1'b1;
                if (hvalid_q) begin
                    sreg_d   = hreg_q;
                    hvalid_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hreg_q      <= '0;
            hvalid_q    <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreg_q      <= hreg_d;
            hvalid_q    <= hvalid_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign din_ready = ~hvalid_q;
    assign x_valid   = (state_q == SHIFT);
    assign x         = x_valid ? out_bit : 1'b0;
    assign busy      = (state_q == SHIFT) | hvalid_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: vector table, directed corner sequences, random vs. bit-queue model.
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         stall = 1'b0;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         word_done;

    int n_vec = 0;
    int n_err = 0;

    serial_bit_feeder #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .stall(stall), .x(x), .x_valid(x_valid), .busy(busy), .word_done(word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         dv;
        logic [W-1:0] d;
        logic         st;
        logic         ex;
        logic         exv;
        logic         erdy;
        logic         ebusy;
        logic         ewd;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic dv, logic [W-1:0] d, logic st, logic ex, logic exv,
                                logic erdy, logic ebusy, logic ewd);
        vec_t v;
        v.dv = dv; v.d = d; v.st = st; v.ex = ex; v.exv = exv;
        v.erdy = erdy; v.ebusy = ebusy; v.ewd = ewd;
        return v;
    endfunction

    // k-th bit of a word in transmission order
    function automatic logic bit_at(logic [W-1:0] w, int k);
`ifdef SERIAL_LSB_FIRST_EN
        return w[k];
`else
        return w[W-1-k];
`endif
    endfunction

    task automatic check(string name, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, ".x"}, x, 1'b0);
        check({tag, ".x_valid"}, x_valid, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".din_ready"}, din_ready, 1'b1);
        check({tag, ".word_done"}, word_done, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] wq[$];
    logic         bq[$];
    int           consumed;
    int           wd_seen;
    int           wd_exp;

    initial begin
        // A5 is bit-palindromic, so this table holds for both shift directions
        tbl[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_idle("post_release");

        // Single word with a 3-cycle stall after the third bit
        for (int i = 0; i < 14; i++) begin
            din_valid = tbl[i].dv;
            din       = tbl[i].d;
            stall     = tbl[i].st;
            tick();
            check($sformatf("tbl%0d.x", i), x, tbl[i].ex);
            check($sformatf("tbl%0d.x_valid", i), x_valid, tbl[i].exv);
            check($sformatf("tbl%0d.din_ready", i), din_ready, tbl[i].erdy);
            check($sformatf("tbl%0d.busy", i), busy, tbl[i].ebusy);
            check($sformatf("tbl%0d.word_done", i), word_done, tbl[i].ewd);
        end

        // Back-to-back B4 then 5A with din held under backpressure
        din_valid = 1'b1;
        din       = 8'hB4;
        tick();
        din       = 8'h5A;
        tick();
        for (int k = 0; k < 16; k++) begin
            logic eb;
            eb = (k < 8) ? bit_at(8'hB4, k) : bit_at(8'h5A, k - 8);
            check($sformatf("b2b%0d.x_valid", k), x_valid, 1'b1);
            check($sformatf("b2b%0d.x", k), x, eb);
            check($sformatf("b2b%0d.word_done", k), word_done, k == 8);
            check($sformatf("b2b%0d.din_ready", k), din_ready, (k == 0) || (k >= 8));
            din_valid = (k < 8);
            tick();
        end
        check("b2b_end.word_done", word_done, 1'b1);
        check("b2b_end.x_valid", x_valid, 1'b0);
        tick();
        check_idle("b2b_after");

        // Reset mid-word after the fourth bit is on x
        din_valid = 1'b1;
        din       = 8'hFF;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("mid.x_before", x, 1'b1);
        reset = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("mid_after%0d.word_done", k), word_done, 1'b0);
            check($sformatf("mid_after%0d.x_valid", k), x_valid, 1'b0);
        end

        // Random traffic against a bit-queue model of the serial stream
        consumed = 0;
        wd_seen  = 0;
        wd_exp   = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rdy_pre, xv_pre, x_pre, st_pre, dv_pre, exp_wd;
            logic [W-1:0] d_pre;
            if (c < 2900) begin
                din_valid = ($urandom_range(0, 1) == 1);
                din       = W'($urandom);
                stall     = ($urandom_range(0, 3) == 0);
            end else begin
                din_valid = 1'b0;
                stall     = 1'b0;
            end
            rdy_pre = din_ready;
            xv_pre  = x_valid;
            x_pre   = x;
            st_pre  = stall;
            dv_pre  = din_valid;
            d_pre   = din;
            tick();
            exp_wd = 1'b0;
            if (!xv_pre && x_pre !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL rnd.x_idle at %0t: got %b expected 0", $time, x_pre);
            end
            if (xv_pre && !st_pre) begin
                if (bq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd.underflow at %0t: got extra bit %b expected none", $time, x_pre);
                end else begin
                    check("rnd.bit", x_pre, bq.pop_front());
                    consumed++;
                    if (consumed % W == 0) begin
                        exp_wd = 1'b1;
                        wd_exp++;
                    end
                end
            end
            if (dv_pre && rdy_pre) begin
                wq.push_back(d_pre);
                for (int k = 0; k < W; k++) bq.push_back(bit_at(d_pre, k));
            end
            if (word_done !== exp_wd) begin
                n_vec++;
                n_err++;
                $display("FAIL rnd.word_done at %0t: got %b expected %b", $time, word_done, exp_wd);
            end
            if (word_done === 1'b1) wd_seen++;
        end
        check_int("rnd.bits_left", bq.size(), 0);
        check_int("rnd.word_done_count", wd_seen, wq.size());
        check_int("rnd.words_consumed", wd_exp, wq.size());
        check_idle("rnd_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
